pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout halt, redirect flush, load-use interlock.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] writeregE,
    input  logic       memtoregE,
    input  logic       branch_takenE,
    input  logic       dmem_reqM,
    input  logic       dmem_readyM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW,
    output logic       halted
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_next_wait_cnt;
    logic       w_mem_stall;
    logic       w_load_use;

    assign w_mem_stall = dmem_reqM & ~dmem_readyM;
    assign w_load_use  = memtoregE & (writeregE != 5'd0) &
                         ((writeregE == rsD) | (writeregE == rtD));

    // State and wait counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= INIT;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // Next-state and Mealy hazard outputs
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        halted = 1'b0;
        case (r_state)
            INIT: begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
                flushW = 1'b1;
                w_next_state    = RUN;
                w_next_wait_cnt = 8'd0;
            end
            RUN: begin
                if (w_mem_stall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    stallM = 1'b1;
                    flushW = 1'b1;
                    w_next_state    = MEMWAIT;
                    w_next_wait_cnt = 8'd1;
                end else if (branch_takenE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (w_load_use) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else begin
                    w_next_state = RUN;
                end
            end
            // E is frozen here, so redirect and load-use are re-evaluated after release
            MEMWAIT: begin
                if (dmem_readyM) begin
                    w_next_state    = RUN;
                    w_next_wait_cnt = 8'd0;
                end else begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    stallM = 1'b1;
                    flushW = 1'b1;
                    if (r_wait_cnt == TIMEOUT_C) begin
                        w_next_state = HALT;
                    end else begin
                        w_next_wait_cnt = r_wait_cnt + 8'd1;
                    end
                end
            end
            HALT: begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
                halted = 1'b1;
            end
            default: begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
                flushW = 1'b1;
                w_next_state    = INIT;
                w_next_wait_cnt = 8'd0;
            end
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    // Stall-cycle and flush-event counters; INIT flushes are not program events
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (stallF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((flushD | flushE) && (r_state != INIT)) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rsD, rtD, writeregE;
    logic       memtoregE, branch_takenE, dmem_reqM, dmem_readyM;
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM, flushW, halted;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .writeregE(writeregE),
        .memtoregE(memtoregE), .branch_takenE(branch_takenE),
        .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .halted(halted)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW,halted}
    logic [8:0] w_out;
    assign w_out = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, halted};

    localparam logic [8:0] P_IDLE = 9'b0000_0000_0;
    localparam logic [8:0] P_INIT = 9'b0000_1111_0;
    localparam logic [8:0] P_LU   = 9'b1100_0100_0;
    localparam logic [8:0] P_RD   = 9'b0000_1100_0;
    localparam logic [8:0] P_MW   = 9'b1111_0001_0;
    localparam logic [8:0] P_HALT = 9'b1111_0001_1;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
        logic       mem;
        logic       br;
        logic       req;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[12];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic mem, input logic br, input logic req, input logic rdy);
        rsD = rs; rtD = rt; writeregE = wr;
        memtoregE = mem; branch_takenE = br;
        dmem_reqM = req; dmem_readyM = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_async_init", {23'd0, w_out}, {23'd0, P_INIT});
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_init", {23'd0, w_out}, {23'd0, P_INIT});
        @(negedge clk);
        #1;
        check("post_reset_run", {23'd0, w_out}, {23'd0, P_IDLE});
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, P_IDLE};
        vecs[1]  = '{5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, P_LU};
        vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, P_IDLE};
        vecs[3]  = '{5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, P_LU};
        vecs[4]  = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, P_IDLE};
        vecs[5]  = '{5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, P_IDLE};
        vecs[6]  = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, P_RD};
        vecs[7]  = '{5'd5, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, P_RD};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, P_IDLE};
        vecs[9]  = '{5'd8, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, P_LU};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, P_RD};
        vecs[11] = '{5'd31, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, P_LU};

        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("in_reset", {23'd0, w_out}, {23'd0, P_INIT});
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("first_init", {23'd0, w_out}, {23'd0, P_INIT});
        @(negedge clk);
        #1;
        check("first_run", {23'd0, w_out}, {23'd0, P_IDLE});

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].rs, vecs[i].rt, vecs[i].wr, vecs[i].mem, vecs[i].br,
                  vecs[i].req, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d", i), {23'd0, w_out}, {23'd0, vecs[i].exp});
        end

        // three-cycle memory wait, redirect/load-use ignored while waiting, then one redirect
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
            else        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            check($sformatf("memwait%0d", i), {23'd0, w_out}, {23'd0, P_MW});
        end
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        check("memwait_ready", {23'd0, w_out}, {23'd0, P_IDLE});
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("redirect_after_wait", {23'd0, w_out}, {23'd0, P_RD});
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("idle_after_redirect", {23'd0, w_out}, {23'd0, P_IDLE});
`ifdef PIPE_PERF_CNT_EN
        check("perf_stall_cycles", stall_cycles, 32'd3);
        check("perf_flush_events", flush_events, 32'd1);
`endif

        // timeout: RUN stall cycle, 4 MEMWAIT cycles, then HALT held regardless of inputs
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            check($sformatf("timeout%0d", k), {23'd0, w_out},
                  {23'd0, (k == 5) ? P_HALT : P_MW});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
            #1;
            check($sformatf("halt_sticky%0d", k), {23'd0, w_out}, {23'd0, P_HALT});
        end
        do_reset();

        // asynchronous reset in the middle of MEMWAIT
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            check($sformatf("pre_reset_wait%0d", k), {23'd0, w_out}, {23'd0, P_MW});
        end
        #2;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_mid_wait", {23'd0, w_out}, {23'd0, P_INIT});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("run_after_mid_reset", {23'd0, w_out}, {23'd0, P_IDLE});
        @(negedge clk);
        drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("loaduse_after_reset", {23'd0, w_out}, {23'd0, P_LU});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
